// File: rtl/led_trail_pwm.sv
// led_trail_pwm: per-channel PWM dimmer that turns the scroller's active-high pattern into
// active-low LED drive with a fading trail. A lit channel runs at full brightness; once it
// drops out of the pattern its brightness decays by DECAY_STEP on every decay tick.
// Optional feature: define LED_GAMMA_EN for a squared (gamma-like) duty mapping, which adds a
// registered duty stage and one cycle of led_state-to-leds latency.
module led_trail_pwm #(
    parameter int unsigned CLOCK_FREQUENCY = 27000000,
    parameter int unsigned PWM_DIV         = 4,
    parameter int unsigned DECAY_DIV       = 270000,
    parameter int unsigned DECAY_STEP      = 16
) (
    input  logic       system_clk,
    input  logic       system_rst_n,
    input  logic [5:0] led_state,
    output logic [5:0] leds
);

    localparam logic [7:0] Step = 8'(DECAY_STEP);

    // Reject parameter values the counters and saturating subtract cannot handle.
    if (CLOCK_FREQUENCY == 0 || PWM_DIV == 0 || DECAY_DIV == 0 ||
        DECAY_STEP == 0 || DECAY_STEP > 255) begin : g_bad_params
        $error("led_trail_pwm: illegal parameter value");
    end

    logic [5:0][7:0] brightness;
    logic [5:0][7:0] brightness_next;
    logic [5:0][7:0] duty;
    logic [7:0]      pwm_cnt;
    logic [31:0]     pwm_pre;
    logic [31:0]     decay_cnt;
    logic            pwm_step;
    logic            decay_tick;
    logic [5:0]      on;

    assign pwm_step   = (pwm_pre == PWM_DIV - 1);
    assign decay_tick = (decay_cnt == DECAY_DIV - 1);

    // Prescaler and free-running 8-bit PWM counter shared by all channels.
    always_ff @(posedge system_clk) begin
        if (!system_rst_n) begin
            pwm_pre <= '0;
            pwm_cnt <= '0;
        end else if (pwm_step) begin
            pwm_pre <= '0;
            pwm_cnt <= pwm_cnt + 8'd1;
        end else begin
            pwm_pre <= pwm_pre + 32'd1;
        end
    end

    // Decay timebase; the tick is the terminal count cycle.
    always_ff @(posedge system_clk) begin
        if (!system_rst_n) begin
            decay_cnt <= '0;
        end else if (decay_tick) begin
            decay_cnt <= '0;
        end else begin
            decay_cnt <= decay_cnt + 32'd1;
        end
    end

    // Brightness next state: a lit channel wins over a simultaneous tick; decay saturates at 0.
    always_comb begin
        brightness_next = brightness;
        for (int i = 0; i < 6; i++) begin
            if (led_state[i]) begin
                brightness_next[i] = 8'd255;
            end else if (decay_tick) begin
                brightness_next[i] = (brightness[i] > Step) ? brightness[i] - Step : 8'd0;
            end
        end
    end

    // Brightness registers.
    always_ff @(posedge system_clk) begin
        if (!system_rst_n) begin
            brightness <= '0;
        end else begin
            brightness <= brightness_next;
        end
    end

`ifdef LED_GAMMA_EN
    // Squared duty (upper byte of the 16-bit product), registered to keep the multiply off
    // the compare path.
    always_ff @(posedge system_clk) begin
        if (!system_rst_n) begin
            duty <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                duty[i] <= 8'((16'(brightness[i]) * 16'(brightness[i])) >> 8);
            end
        end
    end
`else
    // Linear duty: brightness drives the compare directly.
    always_comb begin
        duty = brightness;
    end
`endif

    // Strict less-than compare: duty 0 never lights, duty 255 lights 255 of 256 counts.
    always_comb begin
        on = '0;
        for (int i = 0; i < 6; i++) begin
            on[i] = (pwm_cnt < duty[i]);
        end
    end

    // Registered active-low LED drive.
    always_ff @(posedge system_clk) begin
        if (!system_rst_n) begin
            leds <= '1;
        end else begin
            leds <= ~on;
        end
    end

endmodule

// File: tb/tb_led_trail_pwm.sv
// tb_led_trail_pwm: scoreboard bench for led_trail_pwm with PWM_DIV=1, DECAY_DIV=8,
// DECAY_STEP=100. The stimulus process drives led_state/reset per edge and queues the leds
// value expected after that edge; a monitor process pops and compares after each edge.
// Expected brightness comes from a hand-written schedule of decay/set events.
`timescale 1ns/1ps
module tb_led_trail_pwm;

    localparam int unsigned PwmDiv    = 1;
    localparam int unsigned DecayDiv  = 8;
    localparam int unsigned DecayStep = 100;
`ifdef LED_GAMMA_EN
    localparam bit Gamma = 1'b1;
`else
    localparam bit Gamma = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] led_state;
    logic [5:0] leds;

    always #5 clk = ~clk;

    led_trail_pwm #(
        .CLOCK_FREQUENCY(27000000),
        .PWM_DIV        (PwmDiv),
        .DECAY_DIV      (DecayDiv),
        .DECAY_STEP     (DecayStep)
    ) dut (
        .system_clk  (clk),
        .system_rst_n(rst_n),
        .led_state   (led_state),
        .leds        (leds)
    );

    typedef struct {
        int         at;
        logic [5:0] exp;
        string      tag;
    } item_t;

    item_t      sb[$];
    int         edge_cnt = 0;
    int         n_cmp    = 0;
    int         n_fail   = 0;
    logic [7:0] bpre [6];  // expected brightness before the coming edge
    logic [7:0] dpre [6];  // expected gamma duty before the coming edge

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: after every edge, compare leds against the item queued for that edge.
    initial begin
        item_t it;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].at <= edge_cnt) begin
                it = sb.pop_front();
                n_cmp++;
                if (it.at != edge_cnt || leds !== it.exp) begin
                    n_fail++;
                    $display("FAIL %s: leds=%b at edge %0d, expected %b at edge %0d",
                             it.tag, leds, edge_cnt, it.exp, it.at);
                end
            end
        end
    end

    // Hand table of squared duty for the brightness levels this bench reaches.
    function automatic logic [7:0] gamma_of(input logic [7:0] b);
        case (b)
            8'd255:  return 8'd254;
            8'd155:  return 8'd93;
            8'd55:   return 8'd11;
            default: return 8'd0;
        endcase
    endfunction

    // led_state program for the first run after reset.
    function automatic logic [5:0] ls_a(input int e);
        if (e < 512) return 6'b000001;
        if (e < 544) return 6'b001011;
        if (e < 567) return 6'b000001;
        if (e < 660) return 6'b001001;
        if (e < 690) return 6'b001000;
        if (e < 700) return 6'b111111;
        return 6'b000000;
    endfunction

    // led_state program for the run after the mid-frame reset.
    function automatic logic [5:0] ls_b(input int e);
        if (e >= 300 && e < 304) return 6'b000100;
        return 6'b000000;
    endfunction

    // Drive one edge and queue the leds expected after it. With PWM_DIV=1, pwm_cnt before
    // edge e (counted from reset release) is e mod 256.
    task automatic do_edge(input logic rst_v, input logic [5:0] ls, input int e,
                           input string tag);
        logic [5:0] exp;
        item_t      it;
        @(negedge clk);
        rst_n     = rst_v;
        led_state = ls;
        exp       = '1;
        if (!rst_v) begin
            for (int i = 0; i < 6; i++) begin
                bpre[i] = 8'd0;
                dpre[i] = 8'd0;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                exp[i] = !(8'(e) < (Gamma ? dpre[i] : bpre[i]));
            end
        end
        it.at  = edge_cnt + 1;
        it.exp = exp;
        it.tag = tag;
        sb.push_back(it);
    endtask

    // Hand-computed brightness after edge e (ticks land on edges with e mod 8 == 7).
    task automatic advance(input int ep, input int e);
        for (int i = 0; i < 6; i++) dpre[i] = gamma_of(bpre[i]);
        if (ep == 0) begin
            case (e)
                0:   bpre[0] = 8'd255;
                512: begin bpre[1] = 8'd255; bpre[3] = 8'd255; end
                551: begin bpre[1] = 8'd155; bpre[3] = 8'd155; end
                559: begin bpre[1] = 8'd55;  bpre[3] = 8'd55;  end
                567: begin bpre[1] = 8'd0;   bpre[3] = 8'd255; end  // set wins over tick
                663: bpre[0] = 8'd155;
                671: bpre[0] = 8'd55;
                679: bpre[0] = 8'd0;
                690: for (int i = 0; i < 6; i++) bpre[i] = 8'd255;
                703: for (int i = 0; i < 6; i++) bpre[i] = 8'd155;
                711: for (int i = 0; i < 6; i++) bpre[i] = 8'd55;
                default: ;
            endcase
        end else begin
            case (e)
                300: bpre[2] = 8'd255;
                311: bpre[2] = 8'd155;
                319: bpre[2] = 8'd55;
                327: bpre[2] = 8'd0;
                default: ;
            endcase
        end
    endtask

    // Stimulus.
    initial begin
        rst_n     = 1'b0;
        led_state = 6'b000001;
        for (int i = 0; i < 6; i++) begin
            bpre[i] = 8'd0;
            dpre[i] = 8'd0;
        end
        // Reset held with a lit channel: all LEDs stay off.
        for (int k = 0; k < 3; k++) do_edge(1'b0, 6'b000001, 0, $sformatf("reset1 k=%0d", k));
        for (int e = 0; e < 712; e++) begin
            do_edge(1'b1, ls_a(e), e, $sformatf("run1 e=%0d", e));
            advance(0, e);
        end
        // Mid-frame reset with every channel at 55; reset must dominate a full pattern.
        for (int k = 0; k < 2; k++) do_edge(1'b0, 6'b111111, 0, $sformatf("reset2 k=%0d", k));
        for (int e = 0; e < 400; e++) begin
            do_edge(1'b1, ls_b(e), e, $sformatf("run2 e=%0d", e));
            advance(1, e);
        end
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d items left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
